program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the program loader.
// The slave side is the loader; the master side is the byte source / boot controller.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH:0]   load_len;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic [ADDR_WIDTH:0]   words_loaded;
    logic [31:0]           checksum;

    modport master (
        output start, load_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, words_loaded, checksum
    );

    modport slave (
        input  start, load_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, words_loaded, checksum
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to
// instruction memory from address 0 and holds the datapath in reset until complete.
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.slave   ldr
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] CAP = LW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] words_q, words_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   csum_q, csum_d;
    logic [LW-1:0] len_clamped;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] n);
        return (n > CAP) ? CAP : n;
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] k,
                                                input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    assign len_clamped = clamp_len(ldr.load_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        idx_d   = idx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ldr.start) begin
                    len_d   = len_clamped;
                    words_d = '0;
                    csum_d  = '0;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                // The 2-bit index wraps back to 0 on the fourth byte of each word.
                if (ldr.byte_valid) begin
                    word_d = insert_byte(word_q, idx_q, ldr.byte_in);
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + LW'(1);
                csum_d  = csum_q + word_q;
                state_d = ((words_q + LW'(1)) == len_q) ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode registered state only.
    assign ldr.byte_ready   = (state_q == S_LOAD);
    assign ldr.mem_we       = (state_q == S_WRITE);
    assign ldr.mem_addr     = words_q[ADDR_WIDTH-1:0];
    assign ldr.mem_wdata    = (state_q == S_WRITE) ? word_q : 32'h0;
    assign ldr.cpu_rst      = (state_q != S_DONE);
    assign ldr.done         = (state_q == S_DONE);
    assign ldr.words_loaded = words_q;
    assign ldr.checksum     = csum_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a wide instance (ADDR_WIDTH=8) and a small one (ADDR_WIDTH=2)
// driven from one byte source, checked with vector tables, directed sequences and random loads.
module tb_program_loader;
    logic clk;
    logic rst;
    logic sel;
    logic start;
    logic [8:0] load_len;
    logic [7:0] byte_in;
    logic byte_valid;

    program_loader_if #(.ADDR_WIDTH(8)) ifa ();
    program_loader_if #(.ADDR_WIDTH(2)) ifb ();

    assign ifa.start      = start & ~sel;
    assign ifb.start      = start & sel;
    assign ifa.load_len   = load_len;
    assign ifb.load_len   = load_len[2:0];
    assign ifa.byte_in    = byte_in;
    assign ifb.byte_in    = byte_in;
    assign ifa.byte_valid = byte_valid;
    assign ifb.byte_valid = byte_valid;

    program_loader #(.ADDR_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .ldr(ifa.slave));
    program_loader #(.ADDR_WIDTH(2)) dut_b (.clk(clk), .rst(rst), .ldr(ifb.slave));

    logic        m_ready, m_we, m_cpu_rst, m_done;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_csum;
    logic [8:0]  m_words;

    always_comb begin
        if (sel) begin
            m_ready   = ifb.byte_ready;
            m_we      = ifb.mem_we;
            m_addr    = {6'b0, ifb.mem_addr};
            m_wdata   = ifb.mem_wdata;
            m_cpu_rst = ifb.cpu_rst;
            m_done    = ifb.done;
            m_words   = {6'b0, ifb.words_loaded};
            m_csum    = ifb.checksum;
        end else begin
            m_ready   = ifa.byte_ready;
            m_we      = ifa.mem_we;
            m_addr    = ifa.mem_addr;
            m_wdata   = ifa.mem_wdata;
            m_cpu_rst = ifa.cpu_rst;
            m_done    = ifa.done;
            m_words   = ifa.words_loaded;
            m_csum    = ifa.checksum;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wd_q[$];
    int          wa_q[$];
    logic [31:0] tx_words[$];

    always @(negedge clk) begin
        if (m_we) begin
            wd_q.push_back(m_wdata);
            wa_q.push_back(int'(m_addr));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] len);
        @(negedge clk);
        byte_valid = 1'b0;
        load_len   = len;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wd_q.delete();
        wa_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  t;
        logic hs_seen;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        forever begin
            hs_seen = m_ready;
            @(posedge clk);
            if (hs_seen) break;
            t++;
            if (t > 64) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %0h not taken within 64 cycles", b);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], $urandom_range(0, gapmax));
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!m_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_done"}, 64'(m_done), 64'(1));
    endtask

    // Full load on the selected instance, compared against the supplied expectation.
    task automatic run_load(input string name, input logic [8:0] len, input logic use_b,
                            input int gapmax, input logic [31:0] exp_csum, input int exp_writes);
        int n;
        sel = use_b;
        do_start(len);
        @(negedge clk);
        if (exp_writes == 0) chk({name, "_done_next"}, 64'(m_done), 64'(1));
        else                 chk({name, "_ready_first"}, 64'(m_ready), 64'(1));
        for (int w = 0; w < exp_writes; w++) begin
            send_word(tx_words[w], gapmax);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        wait_done(name);
        chk({name, "_nwrites"}, 64'(wd_q.size()), 64'(exp_writes));
        n = (wd_q.size() < exp_writes) ? wd_q.size() : exp_writes;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", name, i), 64'(wa_q[i]), 64'(i));
            chk($sformatf("%s_data%0d", name, i), 64'(wd_q[i]), 64'(tx_words[i]));
        end
        chk({name, "_csum"}, 64'(m_csum), 64'(exp_csum));
        chk({name, "_words"}, 64'(m_words), 64'(exp_writes));
        chk({name, "_cpu_rst"}, 64'(m_cpu_rst), 64'(0));
        chk({name, "_ready_off"}, 64'(m_ready), 64'(0));
    endtask

    typedef struct packed {
        logic [8:0]       len;
        logic [3:0][31:0] w;
        logic [31:0]      exp_csum;
        int               exp_writes;
        logic             use_b;
        int               gapmax;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sum;
        int          len_r, cap, nw;
        logic        ub;

        tbl[0] = '{len: 9'd1, w: {32'h0, 32'h0, 32'h0, 32'h12345678},
                   exp_csum: 32'h12345678, exp_writes: 1, use_b: 1'b0, gapmax: 0};
        tbl[1] = '{len: 9'd3, w: {32'h0, 32'h00000010, 32'h00000002, 32'hFFFFFFFF},
                   exp_csum: 32'h00000011, exp_writes: 3, use_b: 1'b0, gapmax: 3};
        tbl[2] = '{len: 9'd0, w: {32'h0, 32'h0, 32'h0, 32'h0},
                   exp_csum: 32'h0, exp_writes: 0, use_b: 1'b0, gapmax: 0};
        tbl[3] = '{len: 9'd7, w: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   exp_csum: 32'hAAAAAAAA, exp_writes: 4, use_b: 1'b1, gapmax: 2};
        tbl[4] = '{len: 9'd2, w: {32'h0, 32'h0, 32'h00000001, 32'hDEADBEEF},
                   exp_csum: 32'hDEADBEF0, exp_writes: 2, use_b: 1'b0, gapmax: 1};

        rst = 1'b1; sel = 1'b0; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(m_ready), 64'(0));
        chk("rst_we", 64'(m_we), 64'(0));
        chk("rst_addr", 64'(m_addr), 64'(0));
        chk("rst_wdata", 64'(m_wdata), 64'(0));
        chk("rst_cpu_rst", 64'(m_cpu_rst), 64'(1));
        chk("rst_done", 64'(m_done), 64'(0));
        chk("rst_words", 64'(m_words), 64'(0));
        chk("rst_csum", 64'(m_csum), 64'(0));
        chk("rst_b_cpu_rst", 64'(ifb.cpu_rst), 64'(1));
        chk("rst_b_ready", 64'(ifb.byte_ready), 64'(0));
        rst = 1'b0;

        // Single word, back-to-back bytes, cycle-exact.
        sel = 1'b0;
        do_start(9'd1);
        send_word(32'h12345678, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("sw_we", 64'(m_we), 64'(1));
        chk("sw_addr", 64'(m_addr), 64'(0));
        chk("sw_wdata", 64'(m_wdata), 64'h12345678);
        chk("sw_done_early", 64'(m_done), 64'(0));
        chk("sw_cpu_rst_held", 64'(m_cpu_rst), 64'(1));
        @(negedge clk);
        chk("sw_done", 64'(m_done), 64'(1));
        chk("sw_cpu_rst", 64'(m_cpu_rst), 64'(0));
        chk("sw_words", 64'(m_words), 64'(1));
        chk("sw_csum", 64'(m_csum), 64'h12345678);
        chk("sw_we_off", 64'(m_we), 64'(0));
        chk("sw_nwrites", 64'(wd_q.size()), 64'(1));

        // Zero length, then reload from DONE with a start pulse mid-LOAD.
        do_start(9'd0);
        @(negedge clk);
        chk("z_done", 64'(m_done), 64'(1));
        chk("z_csum", 64'(m_csum), 64'(0));
        chk("z_words", 64'(m_words), 64'(0));
        chk("z_nwrites", 64'(wd_q.size()), 64'(0));
        do_start(9'd2);
        @(negedge clk);
        chk("ig_cpu_rst_reassert", 64'(m_cpu_rst), 64'(1));
        chk("ig_done_clear", 64'(m_done), 64'(0));
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        load_len   = 9'd9;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        send_word(32'h0F0F0F0F, 1);
        @(negedge clk);
        byte_valid = 1'b0;
        wait_done("ig");
        chk("ig_nwrites", 64'(wd_q.size()), 64'(2));
        chk("ig_words", 64'(m_words), 64'(2));
        chk("ig_csum", 64'(m_csum), 64'hB4B4B4B4);

        // Reset after two bytes of the second word.
        do_start(9'd4);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_cpu_rst", 64'(m_cpu_rst), 64'(1));
        chk("mr_words", 64'(m_words), 64'(0));
        chk("mr_csum", 64'(m_csum), 64'(0));
        chk("mr_ready", 64'(m_ready), 64'(0));
        chk("mr_done", 64'(m_done), 64'(0));
        tx_words.delete();
        sum = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tx_words.push_back($urandom);
            sum += tx_words[i];
        end
        run_load("mr_reload", 9'd4, 1'b0, 1, sum, 4);

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            tx_words.delete();
            for (int b = 0; b < 4; b++) tx_words.push_back(tbl[i].w[b]);
            run_load($sformatf("vec%0d", i), tbl[i].len, tbl[i].use_b, tbl[i].gapmax,
                     tbl[i].exp_csum, tbl[i].exp_writes);
        end

        // Random loads against a word-list model: writes = min(len, capacity).
        for (int r = 0; r < 10; r++) begin
            ub    = ($urandom_range(0, 3) == 0);
            cap   = ub ? 4 : 256;
            len_r = ub ? $urandom_range(0, 7) : $urandom_range(0, 12);
            nw    = (len_r > cap) ? cap : len_r;
            tx_words.delete();
            sum = 32'h0;
            for (int i = 0; i < nw; i++) begin
                tx_words.push_back($urandom);
                sum += tx_words[i];
            end
            run_load($sformatf("rnd%0d", r), 9'(len_r), ub, 3, sum, nw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
